if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch unit feeding the IF/ID pipeline register. It owns the fetch PC, issues in-order requests to instruction memory over a valid/ready port, and tags each returned instruction with its PC in a small reorder-free prefetch queue. It presents one `{pc, inst}` pair per cycle to the decode side. On a redirect from the execute stage (jal, jalr, taken branch) it discards all queued and in-flight fetches.

## Interface
Parameters:
- `XLEN`, 64, width of PC and addresses
- `INST_W`, 32, instruction width
- `DEPTH`, 4, prefetch queue entries (power of two, ≥2)
- `RESET_PC`, 64'h8000_0000, first fetch address after reset

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `redirect_valid`  in  1  flush request from execute stage
- `redirect_pc`  in  XLEN  new fetch target; bits [1:0] ignored (treated as 0)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  XLEN  fetch address, always 4-byte aligned
- `imem_resp_valid`  in  1  instruction returned, in request order, never earlier than the cycle after acceptance, no backpressure
- `imem_resp_inst`  in  INST_W  returned instruction
- `out_valid`  out  1  head entry ready for IF/ID
- `out_ready`  in  1  IF/ID accepts
- `out_pc`  out  XLEN  PC of head entry
- `out_inst`  out  INST_W  instruction of head entry

## Operation
- State: `fetch_pc`, circular queue of DEPTH entries `{pc, inst, filled}`, pointers `head`, `fill`, `tail`, occupancy `count`, discard counter `drop_cnt`.
- Issue: `imem_req_valid = started && !redirect_valid && (count + drop_cnt < DEPTH)`. `imem_req_addr = fetch_pc`. On accept, allocate entry at `tail` with `pc=fetch_pc`, `filled=0`; `fetch_pc += 4`.
- Response: if `drop_cnt != 0`, decrement `drop_cnt`, discard data. Otherwise write `inst` into entry at `fill`, set `filled`, advance `fill`. A response with no unfilled entry and `drop_cnt==0` is a protocol violation and is ignored.
- Output: `out_valid = head.filled && !redirect_valid`; `out_pc/out_inst` = head entry. On `out_valid && out_ready`, free head.
- Simultaneous allocate and free in one cycle: `count` unchanged.
- Redirect (highest priority): `fetch_pc = {redirect_pc[XLEN-1:2],2'b0}`. All entries invalidated, pointers and `count` to 0. New `drop_cnt` = old `drop_cnt` + allocated-but-unfilled entries, minus 1 if a response arrives this cycle (that response is itself discarded). No request is issued and no output fires in the redirect cycle.
- Back-to-back redirects: each applies fully; the last one wins for `fetch_pc`.
- Arithmetic: PC increment wraps modulo 2^XLEN. `drop_cnt` and `count` are $clog2(DEPTH)+1 bits, and their sum never exceeds DEPTH.

## Timing
- Reset (`rst` low, async): `fetch_pc=RESET_PC`, queue empty, `drop_cnt=0`, `started=0`. Outputs: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `out_valid=0`, `out_pc=0`, `out_inst=0`.
- `started` sets on the first edge after release, so the request for RESET_PC is valid in cycle 1 after deassertion.
- Latency: request accepted at edge k, response in cycle k+1, `out_valid` in cycle k+2 (no bypass).
- Throughput: 1 instr/cycle sustained with single-cycle memory and `out_ready` held high, for DEPTH≥3.
- Reset asserted mid-operation: all state cleared immediately. Responses to pre-reset requests are the memory's responsibility and are not tracked.

## Test plan
- Reset release, single-cycle memory, `out_ready=1` → requests to 0x8000_0000, 0x8000_0004, …; first `out_valid` two cycles after first accept; one pc/inst pair per cycle thereafter.
- `out_ready=0` held → exactly DEPTH (4) requests issued, then `imem_req_valid=0`; releasing `out_ready` drains pc 0x8000_0000…0x8000_000C in order.
- Memory with 3-cycle response latency, then redirect to 0x8000_0100 with 2 requests in flight → both late responses dropped; next `out_pc=0x8000_0100`; no stale instruction appears.
- Redirect in the same cycle as a response and an `out_ready` handshake → response discarded, `out_valid=0` that cycle, next fetch address = redirect target.
- `redirect_pc=0x8000_0203` → `imem_req_addr=0x8000_0200`; `imem_req_ready=0` for 5 cycles → address held stable, no allocation.
- `rst` pulsed low with a full queue → `out_valid` drops asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues in-order imem requests
// and queues {pc, inst} pairs for the IF/ID register, flushing on redirect.
module if_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0]   fetch_pc;
  logic              started;
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled;
  ptr_t              head;
  ptr_t              fill;
  ptr_t              tail;
  cnt_t              count;
  cnt_t              pend;
  cnt_t              drop_cnt;

  logic [CW:0]       occ;
  logic              req_fire;
  logic              resp_drop;
  logic              resp_fill;
  logic              out_fire;
  cnt_t              live_drop;
  cnt_t              flush_drop;

  assign occ            = {1'b0, count} + {1'b0, drop_cnt};
  assign imem_req_valid = started && !redirect_valid && (occ < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt == '0)
                   && (pend != '0) && !redirect_valid;

  assign out_valid = filled[head] && !redirect_valid;
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = pc_q[head];
  assign out_inst  = inst_q[head];

  // Everything still owed by memory becomes a discard on flush
  assign live_drop  = drop_cnt + pend;
  assign flush_drop = live_drop
                    - {{PW{1'b0}}, imem_resp_valid && (live_drop != '0)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      started  <= 1'b0;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        head     <= '0;
        fill     <= '0;
        tail     <= '0;
        count    <= '0;
        pend     <= '0;
        drop_cnt <= flush_drop;
        filled   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc       <= fetch_pc + {{(XLEN-3){1'b0}}, 3'd4};
          tail           <= tail + ptr_t'(1);
          filled[tail]   <= 1'b0;
        end
        if (resp_drop)
          drop_cnt <= drop_cnt - cnt_t'(1);
        if (resp_fill) begin
          fill         <= fill + ptr_t'(1);
          filled[fill] <= 1'b1;
        end
        if (out_fire) begin
          head         <= head + ptr_t'(1);
          filled[head] <= 1'b0;
        end
        pend  <= pend + {{PW{1'b0}}, req_fire}
                      - {{PW{1'b0}}, resp_fill};
        count <= count + {{PW{1'b0}}, req_fire}
                       - {{PW{1'b0}}, out_fire};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      if (req_fire)
        pc_q[tail] <= fetch_pc;
      if (resp_fill)
        inst_q[fill] <= imem_resp_inst;
    end
  end

endmodule
